// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pixel path: state encoding, default frame
// geometry and a counter-width helper.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_e;

    localparam int unsigned SOBEL_IMG_WIDTH  = 6;
    localparam int unsigned SOBEL_IMG_HEIGHT = 6;
    localparam int unsigned SOBEL_DATA_WIDTH = 8;
    localparam int unsigned NUM_PIXELS       = SOBEL_IMG_WIDTH * SOBEL_IMG_HEIGHT;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sobel_valid_delay.sv
// Fixed-depth shift register that carries {valid,last} alongside the memory
// read latency so the pixel data can be qualified when it arrives.
module sobel_valid_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    input  logic last_i,
    output logic valid_o,
    output logic last_o
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] last_q,  last_d;

    always_comb begin
        valid_d    = valid_q;
        last_d     = last_q;
        valid_d[0] = valid_i;
        last_d[0]  = last_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            last_d[i]  = last_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign last_o  = last_q[DEPTH-1];

endmodule

// File: rtl/sobel_pixel_streamer.sv
// Reads one frame from a synchronous-read pixel memory in raster order and
// emits it as a gap-free done_o-qualified stream for the Sobel window buffer.
module sobel_pixel_streamer
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH   = SOBEL_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT  = SOBEL_IMG_HEIGHT,
    parameter int unsigned DATA_WIDTH  = SOBEL_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic [DATA_WIDTH-1:0] grayscale_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  frame_end_o
);

    localparam int unsigned CW = cnt_width(IMG_WIDTH);
    localparam int unsigned RW = cnt_width(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_en_q, rd_en_d;
    logic [DATA_WIDTH-1:0] gray_q, gray_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  frame_end_q, frame_end_d;

    logic fetch_last;
    logic dly_valid;
    logic dly_last;

    assign fetch_last = rd_en_q && (col_q == COL_LAST) && (row_q == ROW_LAST);

    sobel_valid_delay #(
        .DEPTH (MEM_LATENCY)
    ) u_valid_delay (
        .clk     (clk),
        .rst     (rst),
        .valid_i (rd_en_q),
        .last_i  (fetch_last),
        .valid_o (dly_valid),
        .last_o  (dly_last)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        addr_d      = addr_q;
        rd_en_d     = rd_en_q;
        busy_d      = busy_q;
        // Output stage is a plain register of the aligned read data; zero when idle.
        gray_d      = dly_valid ? mem_data_i : '0;
        done_d      = dly_valid;
        frame_end_d = dly_valid && dly_last;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                    busy_d  = 1'b1;
                    rd_en_d = 1'b1;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            FETCH: begin
                if (fetch_last) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Leave once the last pixel has been presented.
                if (frame_end_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            rd_en_q     <= 1'b0;
            gray_q      <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            rd_en_q     <= rd_en_d;
            gray_q      <= gray_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign mem_rd_en_o = rd_en_q;
    assign mem_addr_o  = addr_q;
    assign grayscale_o = gray_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign frame_end_o = frame_end_q;

endmodule

// File: tb/tb_sobel_pixel_streamer.sv
// Directed bench: three streamer instances (6x6 latency 1, 6x6 latency 3,
// 4x3 latency 1) each fed by a behavioural synchronous-read memory.
module tb_sobel_pixel_streamer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: 6x6, latency 1, mem[a] = a+1
    logic       a_start, a_rd, a_done, a_busy, a_fe;
    logic [5:0] a_addr;
    logic [7:0] a_mdata, a_gray;
    // Instance B: 6x6, latency 3, mem[a] = a+1
    logic       b_start, b_rd, b_done, b_busy, b_fe;
    logic [5:0] b_addr;
    logic [7:0] b_mdata, b_gray, b_p1, b_p2;
    // Instance C: 4x3, latency 1, mem[a] = 255-a
    logic       c_start, c_rd, c_done, c_busy, c_fe;
    logic [5:0] c_addr;
    logic [7:0] c_mdata, c_gray;

    sobel_pixel_streamer #(
        .IMG_WIDTH(6), .IMG_HEIGHT(6), .DATA_WIDTH(8), .ADDR_WIDTH(6), .MEM_LATENCY(1)
    ) dut_a (
        .clk(clk), .rst(rst), .start_i(a_start), .mem_rd_en_o(a_rd), .mem_addr_o(a_addr),
        .mem_data_i(a_mdata), .grayscale_o(a_gray), .done_o(a_done), .busy_o(a_busy),
        .frame_end_o(a_fe)
    );

    sobel_pixel_streamer #(
        .IMG_WIDTH(6), .IMG_HEIGHT(6), .DATA_WIDTH(8), .ADDR_WIDTH(6), .MEM_LATENCY(3)
    ) dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .mem_rd_en_o(b_rd), .mem_addr_o(b_addr),
        .mem_data_i(b_mdata), .grayscale_o(b_gray), .done_o(b_done), .busy_o(b_busy),
        .frame_end_o(b_fe)
    );

    sobel_pixel_streamer #(
        .IMG_WIDTH(4), .IMG_HEIGHT(3), .DATA_WIDTH(8), .ADDR_WIDTH(6), .MEM_LATENCY(1)
    ) dut_c (
        .clk(clk), .rst(rst), .start_i(c_start), .mem_rd_en_o(c_rd), .mem_addr_o(c_addr),
        .mem_data_i(c_mdata), .grayscale_o(c_gray), .done_o(c_done), .busy_o(c_busy),
        .frame_end_o(c_fe)
    );

    // Synchronous-read memories with the matching latencies
    always @(posedge clk) begin
        a_mdata <= 8'(a_addr + 6'd1);
        b_p1    <= 8'(b_addr + 6'd1);
        b_p2    <= b_p1;
        b_mdata <= b_p2;
        c_mdata <= 8'd255 - 8'(c_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // j = cycles since the start edge (j<=0 means idle); values counted by the bench.
    task automatic chk_stream(input string tag, input int j, input int lat, input int n,
                              input int v0, input int stp,
                              input logic rd, input logic [5:0] ad, input logic [7:0] g,
                              input logic d, input logic b, input logic fe);
        logic e_rd, e_d, e_b, e_fe;
        int   e_ad, e_g;
        e_rd = (j >= 1) && (j <= n);
        e_ad = e_rd ? j - 1 : 0;
        e_d  = (j >= lat + 2) && (j <= lat + 1 + n);
        e_g  = e_d ? (v0 + stp * (j - lat - 2)) & 255 : 0;
        e_fe = (j == lat + 1 + n);
        e_b  = (j >= 1) && (j <= lat + 1 + n);
        chk($sformatf("%s.rd[%0d]", tag, j),   rd, e_rd);
        chk($sformatf("%s.addr[%0d]", tag, j), ad, e_ad);
        chk($sformatf("%s.gray[%0d]", tag, j), g,  e_g);
        chk($sformatf("%s.done[%0d]", tag, j), d,  e_d);
        chk($sformatf("%s.busy[%0d]", tag, j), b,  e_b);
        chk($sformatf("%s.fe[%0d]", tag, j),   fe, e_fe);
    endtask

    task automatic chk_a(input string tag, input int j);
        chk_stream(tag, j, 1, 36, 1, 1, a_rd, a_addr, a_gray, a_done, a_busy, a_fe);
    endtask

    initial begin
        int rd_count;

        rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_a("rst_a", 0);
        chk_stream("rst_b", 0, 3, 36, 1, 1, b_rd, b_addr, b_gray, b_done, b_busy, b_fe);
        chk_stream("rst_c", 0, 1, 12, 255, -1, c_rd, c_addr, c_gray, c_done, c_busy, c_fe);
        rst = 1'b0;
        @(negedge clk);

        // Single frame on all three instances
        a_start = 1'b1; b_start = 1'b1; c_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
            end
            chk_a("f1_a", k);
            chk_stream("f1_b", k, 3, 36, 1, 1, b_rd, b_addr, b_gray, b_done, b_busy, b_fe);
            chk_stream("f1_c", k, 1, 12, 255, -1, c_rd, c_addr, c_gray, c_done, c_busy, c_fe);
        end

        // start held high: second frame begins at the IDLE re-entry edge
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 85; k++) begin
            @(negedge clk);
            if (k == 40) a_start = 1'b0;
            chk_a("b2b_a", (k <= 38) ? k : k - 39);
        end

        // Extra start during FETCH (while pixel 10 is on the output) is ignored
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        rd_count = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 1 || k == 13) a_start = 1'b0;
            if (a_rd) rd_count++;
            chk_a("ign_a", k);
            if (k == 12) a_start = 1'b1;
        end
        chk("ign_rd_count", rd_count, 36);

        // Reset mid-frame when grayscale_o = 20
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1) a_start = 1'b0;
            chk_a("mid_a", k);
        end
        rst = 1'b1;
        @(negedge clk);
        chk_a("mid_rst_a", 0);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk_a("post_rst_a", 0);
        end
        a_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) a_start = 1'b0;
            chk_a("fresh_a", k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobel_pixel_streamer.md
Name: sobel_pixel_streamer

Overview:
- Transmit-side source for the Sobel window buffer. On a start pulse it reads one grayscale frame from a synchronous-read pixel memory in raster order.
- It emits the frame as a gap-free stream on grayscale_o, qualified by done_o. These outputs connect directly to sobel_data_buffer grayscale_i/done_i.
- Owns address generation, read-latency alignment and frame framing. There is no backpressure, because the downstream buffer has none.

Parameters:
- IMG_WIDTH, 6, pixels per row
- IMG_HEIGHT, 6, rows per frame
- DATA_WIDTH, 8, grayscale pixel width
- ADDR_WIDTH, 6, memory address width; must satisfy 2**ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT
- MEM_LATENCY, 1, cycles from mem_rd_en_o/mem_addr_o to valid mem_data_i (1..4)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  request one frame; sampled only in IDLE
- mem_rd_en_o  out  1  memory read strobe
- mem_addr_o  out  ADDR_WIDTH  read address, row*IMG_WIDTH+col
- mem_data_i  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after strobe
- grayscale_o  out  DATA_WIDTH  pixel to window buffer
- done_o  out  1  pixel-valid / frame-active, high for exactly IMG_WIDTH*IMG_HEIGHT consecutive cycles
- busy_o  out  1  high from the cycle after start is accepted until the cycle after the last pixel
- frame_end_o  out  1  one-cycle pulse coincident with the last pixel of the frame

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. Every register, including the latency pipe, clears when rst is high at a clock edge.
- Reset values: mem_rd_en_o=0, mem_addr_o=0, grayscale_o=0, done_o=0, busy_o=0, frame_end_o=0, state=IDLE.
- Frame size: N = IMG_WIDTH*IMG_HEIGHT.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - start_i=1 at edge T moves to FETCH.
  - busy_o=1 from T+1.
  - mem_rd_en_o=1 and mem_addr_o=0 from T+1.
- FETCH:
  - mem_rd_en_o held 1; mem_addr_o increments by 1 every cycle.
  - col and row counters track the address: col wraps at IMG_WIDTH-1, incrementing row.
  - After the address N-1 cycle, go to DRAIN; mem_rd_en_o drops to 0 and mem_addr_o returns to 0.
- Latency pipe:
  - mem_rd_en_o is delayed by a MEM_LATENCY-deep valid shift register, along with a last-flag that marks address N-1.
  - When the delayed valid is 1, mem_data_i is registered into grayscale_o and done_o=1 next cycle.
  - First done_o=1 at T+1+MEM_LATENCY+1; the first pixel is mem[0].
  - Done_o is continuous for N cycles with no bubbles.
- Output hold: when done_o=0, grayscale_o holds 0. The bench checks this.
- DRAIN: wait until the delayed last-flag emerges.
  - frame_end_o=1 with the last pixel.
  - Next cycle: done_o=0, busy_o=0, state IDLE.
- Start while busy: start_i in FETCH or DRAIN is ignored and not queued.
- Back-to-back frames: start_i may be high in the cycle IDLE is re-entered. The gap between frames is then at least MEM_LATENCY+2 cycles with done_o=0. This gap is needed because the window buffer resets its line state on the done_i falling edge.
- Reset mid-frame: all outputs zero on the next edge. Pipe contents are discarded with no partial frame_end_o. A new start_i after reset produces a full frame from address 0.
- Widths:
  - Counters use $clog2 widths.
  - The address is an incrementing counter, not a multiplier.
  - No arithmetic is performed on pixel data.

Decomposition:
- Shared package sobel_pkg:
  - state encoding enum (IDLE/FETCH/DRAIN)
  - IMG_WIDTH, IMG_HEIGHT, DATA_WIDTH defaults, shared with sobel_data_buffer
  - NUM_PIXELS constant
- One sub-module: sobel_valid_delay. Parameterised MEM_LATENCY-deep shift register carrying {valid,last}, with synchronous reset.
- Everything else stays flat.

Test Plan:
- Memory preloaded with mem[a]=a+1, MEM_LATENCY=1, start_i pulsed at cycle 2 -> done_o high cycles 5..40 exactly, grayscale_o = 1,2,...,36 in order, frame_end_o only at cycle 40 with value 36, busy_o low at cycle 41.
- Same memory, MEM_LATENCY=3 -> done_o window shifts by +2 cycles, identical 36-value sequence, still no gaps.
- start_i held high continuously -> second frame begins with done_o low for at least MEM_LATENCY+2 cycles between frames, each frame exactly 36 pixels 1..36.
- start_i pulsed again during FETCH at pixel 10 -> ignored, exactly one frame of 36 pixels, no extra mem_rd_en_o.
- rst asserted when grayscale_o=20 -> next edge all outputs 0 and no frame_end_o; a fresh start then yields a full 1..36 frame.
- IMG_WIDTH=4, IMG_HEIGHT=3, mem[a]=255-a -> 12 pixels 255..244, mem_addr_o sequence 0..11 once, col/row wrap at col 3 observed via addresses 3→4 and 7→8.
